// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: default byte width, FIFO pointer sizing,
// and the width of the optional dropped-byte counter.
package uart_pkg;

  localparam int unsigned UART_WIDTH = 8;
  localparam int unsigned DROP_CNT_W = 8;

  // Pointer width for a power-of-two FIFO depth
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one combinational read port.
// The storage is deliberately not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = UART_WIDTH,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [fifo_ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [fifo_ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive byte FIFO behind the UART receiver, with level flags and a
// sticky overflow flag. Define UART_RX_FIFO_DROP_CNT_EN to add the saturating drop_cnt output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = UART_WIDTH,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       wr_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [fifo_ptr_w(DEPTH):0] count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       ovf_clr
`ifdef UART_RX_FIFO_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]      drop_cnt
`endif
);

  localparam int unsigned PW = fifo_ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;
  logic [WIDTH-1:0] mem_rdata;

  // Status decoded from the registered count only
  assign rd_valid    = (count_q != '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AFULL_THRESH));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign rd_data     = rd_valid ? mem_rdata : '0;

  // A write into a full FIFO is still accepted when the head leaves in the same cycle
  assign pop  = rd_valid & rd_ready;
  assign push = wr_valid & (~full | pop);
  assign drop = wr_valid & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = drop | (overflow_q & ~ovf_clr);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // A drop in the clearing cycle restarts the count at one
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (ovf_clr) begin
        drop_cnt_d = DROP_CNT_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end else if (ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, AFULL_THRESH=12) with hand-computed expectations.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       ovf_clr;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  uart_rx_fifo #(
    .WIDTH        (8),
    .DEPTH        (16),
    .AFULL_THRESH (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    wr_data  = '0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 1: async reset mid-traffic, no clock edge needed
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("t1_count5", 32'(count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_async_count", 32'(count), 32'd0);
    chk("t1_async_valid", 32'(rd_valid), 32'd0);
    chk("t1_async_ovf", 32'(overflow), 32'd0);
    chk("t1_async_data", 32'(rd_data), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // 2: single byte
    push(8'hA5);
    chk("t2_valid", 32'(rd_valid), 32'd1);
    chk("t2_data", 32'(rd_data), 32'hA5);
    chk("t2_count", 32'(count), 32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t2_count0", 32'(count), 32'd0);
    chk("t2_valid0", 32'(rd_valid), 32'd0);

    // 3: fill with back-to-back strobes, watching the almost_full threshold
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (i == 10) chk("t3_afull_at11", 32'(almost_full), 32'd0);
      if (i == 11) chk("t3_afull_at12", 32'(almost_full), 32'd1);
      if (i == 14) chk("t3_full_at15", 32'(full), 32'd0);
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count16", 32'(count), 32'd16);

    // 4: overflow
    push(8'h55);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_count", 32'(count), 32'd16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    chk("t4_dcnt1", 32'(drop_cnt), 32'd1);
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_clr_ovf", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    chk("t4_clr_dcnt", 32'(drop_cnt), 32'd0);
`endif
    ovf_clr = 1'b1;
    push(8'h66);
    ovf_clr = 1'b0;
    chk("t4_set_wins", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    chk("t4_dcnt_load1", 32'(drop_cnt), 32'd1);
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_clr2", 32'(overflow), 32'd0);
    chk("t4_head_kept", 32'(rd_data), 32'h00);

    // 5: full + write + pop; 0x00 leaves, 0x77 enters at the wrapped write slot
    chk("t5_pre_data", 32'(rd_data), 32'h00);
    rd_ready = 1'b1;
    push(8'h77);
    rd_ready = 1'b0;
    chk("t5_count16", 32'(count), 32'd16);
    chk("t5_no_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) pop_chk($sformatf("t5_pop%0d", i), 8'(i));
    pop_chk("t5_pop_last", 8'h77);
    chk("t5_empty", 32'(rd_valid), 32'd0);
    chk("t5_count0", 32'(count), 32'd0);

    // Empty + rd_ready alone: nothing happens
    rd_ready = 1'b1;
    tick();
    chk("t5_empty_rdy", 32'(count), 32'd0);
    // Empty + wr_valid + rd_ready: byte retained
    push(8'h3C);
    rd_ready = 1'b0;
    chk("t5_keep_count", 32'(count), 32'd1);
    pop_chk("t5_keep", 8'h3C);

    // 3 (cont.): after wrap, push 0x10..0x13 and read back
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    chk("t3_count4", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("t3_rb%0d", i), 8'(8'h10 + i));

    // 6: receiver-style frames: isolated strobes with idle gaps, consumer stalled
    for (int f = 0; f < 3; f++) begin
      push(8'(8'h31 + f));
      repeat (10) tick();
    end
    chk("t6_count3", 32'(count), 32'd3);
    for (int f = 0; f < 3; f++) pop_chk($sformatf("t6_rx%0d", f), 8'(8'h31 + f));
    chk("t6_empty", 32'(rd_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
